prng_die_roller: RTL

PRNG_DIE_ROLLER -- requirements
Module: prng_die_roller

---
 rtl/prng_die_roller.sv | 104 ++++++++++
 1 files changed

// File: rtl/prng_die_roller.sv
// Turns raw 3-bit PRNG samples into die values 1..6 through a small FIFO.
// A repetition health test latches a failure and flushes the FIFO.
module prng_die_roller #(
  parameter int FIFO_DEPTH = 4,
  parameter int REP_LIMIT  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [2:0] in_sample,
  input  logic       roll_ready,
  input  logic       clear_fail,
  output logic       roll_valid,
  output logic [2:0] roll_data,
  output logic [4:0] fifo_count,
  output logic       health_fail,
  output logic [7:0] reject_cnt,
  output logic [7:0] drop_cnt
);

  localparam int          AW     = $clog2(FIFO_DEPTH);
  localparam logic [4:0]  DEPTH  = 5'(FIFO_DEPTH);
  localparam logic [7:0]  LIM    = 8'(REP_LIMIT);

  typedef enum logic {RUN, FAIL} state_t;

  state_t                     state;
  logic [FIFO_DEPTH-1:0][2:0] mem;
  logic [AW-1:0]              wptr, rptr;
  logic [7:0]                 rep_cnt, rep_nxt;
  logic [2:0]                 prev;
  logic                       is_die, full, rd, wr, drop, trip;

  // rep_cnt == 0 means "no previous sample to compare against"
  always_comb begin
    full    = (fifo_count == DEPTH);
    is_die  = (in_sample != 3'd0) && (in_sample != 3'd7);
    rd      = roll_valid && roll_ready;
    rep_nxt = 8'd1;
    if (rep_cnt != 8'd0 && in_sample == prev)
      rep_nxt = (rep_cnt >= LIM) ? LIM : rep_cnt + 8'd1;
    trip    = in_valid && (rep_nxt == LIM);
    wr      = in_valid && is_die && (state == RUN) && !trip && (!full || rd);
    drop    = in_valid && is_die && (state == RUN) && !trip && full && !rd;
  end

  assign roll_valid = (fifo_count != 5'd0);
  assign roll_data  = roll_valid ? mem[rptr] : 3'd0;

  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= in_sample;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      health_fail <= 1'b0;
      fifo_count  <= 5'd0;
      wptr        <= '0;
      rptr        <= '0;
      rep_cnt     <= 8'd0;
      prev        <= 3'd0;
      reject_cnt  <= 8'd0;
      drop_cnt    <= 8'd0;
    end else begin
      if (in_valid) begin
        prev <= in_sample;
        if (!is_die && reject_cnt != 8'hFF) reject_cnt <= reject_cnt + 8'd1;
      end
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      case (state)
        RUN: begin
          if (in_valid) rep_cnt <= rep_nxt;
          if (trip) begin
            state       <= FAIL;
            health_fail <= 1'b1;
            fifo_count  <= 5'd0;
            wptr        <= '0;
            rptr        <= '0;
          end else begin
            if (rd) rptr <= rptr + 1'b1;
            if (wr) wptr <= wptr + 1'b1;
            if (wr && !rd)      fifo_count <= fifo_count + 5'd1;
            else if (rd && !wr) fifo_count <= fifo_count - 5'd1;
          end
        end
        FAIL: begin
          // a fresh trip beats a simultaneous clear
          if (trip) begin
            rep_cnt <= rep_nxt;
          end else if (clear_fail) begin
            state       <= RUN;
            health_fail <= 1'b0;
            rep_cnt     <= 8'd0;
          end else if (in_valid) begin
            rep_cnt <= rep_nxt;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule
